// File: rtl/i2c_slave_ctrl.sv
// I2C slave transaction controller: detects START/STOP, frames 9-bit byte slots,
// checks the device address and turns written bytes into register-write strobes.
module i2c_slave_ctrl #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  input  logic [7:0] byte_data,
  output logic       byte_en,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_REG,
    S_DATA,
    S_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic       scl_q, scl_qq, sda_q, sda_qq;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       byte_en_q, byte_en_d;
  logic [7:0] reg_addr_q, reg_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       wr_valid_q, wr_valid_d;
  logic       busy_q, busy_d;

  logic scl_rise, scl_fall, start_det, stop_det, addr_ok;

  assign scl_rise  = scl_q & ~scl_qq;
  assign scl_fall  = ~scl_q & scl_qq;
  assign start_det = scl_q & scl_qq & sda_qq & ~sda_q;
  assign stop_det  = scl_q & scl_qq & ~sda_qq & sda_q;
  assign addr_ok   = (byte_data[7:1] == DEV_ADDR) && !byte_data[0];

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_en_d  = (state_q == S_ADDR) || (state_q == S_REG) || (state_q == S_DATA);
    // Pointer advances the cycle after each write strobe.
    reg_addr_d = wr_valid_q ? reg_addr_q + 8'd1 : reg_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    busy_d     = busy_q;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      byte_en_d = 1'b0;
    end else if (stop_det) begin
      state_d   = S_IDLE;
      bit_cnt_d = 4'd0;
      byte_en_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_REG, S_DATA: begin
          if (scl_rise && (bit_cnt_q < 4'd9)) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            // 8th rise: last address bit already latched by the receiver.
            if ((state_q == S_ADDR) && (bit_cnt_q == 4'd7)) begin
              if (addr_ok) begin
                busy_d = 1'b1;
              end else begin
                state_d   = S_IGNORE;
                byte_en_d = 1'b0;
                busy_d    = 1'b0;
              end
            end
            if (bit_cnt_q == 4'd8) begin
              if (state_q == S_REG) begin
                reg_addr_d = byte_data;
              end else if (state_q == S_DATA) begin
                wr_data_d  = byte_data;
                wr_valid_d = 1'b1;
              end
            end
          end else if (scl_fall && (bit_cnt_q == 4'd9)) begin
            // Slot boundary: one-cycle enable drop clears the receiver's counter.
            bit_cnt_d = 4'd0;
            byte_en_d = 1'b0;
            if (state_q == S_ADDR) begin
              state_d = S_REG;
            end else if (state_q == S_REG) begin
              state_d = S_DATA;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      scl_q      <= 1'b1;
      scl_qq     <= 1'b1;
      sda_q      <= 1'b1;
      sda_qq     <= 1'b1;
      bit_cnt_q  <= 4'd0;
      byte_en_q  <= 1'b0;
      reg_addr_q <= 8'h00;
      wr_data_q  <= 8'h00;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_q      <= scl_i;
      scl_qq     <= scl_q;
      sda_q      <= sda_i;
      sda_qq     <= sda_q;
      bit_cnt_q  <= bit_cnt_d;
      byte_en_q  <= byte_en_d;
      reg_addr_q <= reg_addr_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign byte_en  = byte_en_q;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_valid = wr_valid_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: bus-level master, simple byte-receiver model and a
// transaction-level model predicting write strobes, busy and ACK behaviour.
module tb_i2c_slave_ctrl;
  localparam logic [6:0] DEV = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_i = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic [7:0] byte_data;
  logic       byte_en, wr_valid, busy;
  logic [7:0] reg_addr, wr_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  i2c_slave_ctrl #(.DEV_ADDR(DEV)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_bus), .byte_data(byte_data),
    .byte_en(byte_en), .reg_addr(reg_addr), .wr_data(wr_data),
    .wr_valid(wr_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte receiver: shifts on raw SCL rises, ACKs the 9th slot while enabled.
  logic       rx_prev = 1'b1;
  logic       rx_ack = 1'b0;
  logic [3:0] rx_cnt = 4'd0;
  logic [7:0] rx_data = 8'h00;
  assign sda_bus   = sda_m & ~rx_ack;
  assign byte_data = rx_data;

  always @(posedge clk) begin
    rx_prev <= scl_i;
    if (!byte_en) begin
      rx_cnt <= 4'd0;
      rx_ack <= 1'b0;
    end else begin
      if (scl_i && !rx_prev && rx_cnt < 4'd8) begin
        rx_data <= {rx_data[6:0], sda_bus};
        rx_cnt  <= rx_cnt + 4'd1;
      end
      if (!scl_i && rx_prev) begin
        if (rx_ack) rx_ack <= 1'b0;
        else if (rx_cnt == 4'd8) rx_ack <= 1'b1;
      end
    end
  end

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  obs_q[$];
  wr_t  obs_t;
  bit   m_in_txn = 1'b0;
  bit   m_addressed = 1'b0;
  int   m_idx = 0;
  logic [7:0] m_ptr = 8'h00;
  bit   busy_exp = 1'b0;
  bit   busy_dc = 1'b1;
  int   en_falls = 0;
  logic en_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (byte_en === 1'b0 && en_prev === 1'b1) en_falls++;
    en_prev = byte_en;
    if (wr_valid) begin
      obs_t.cyc  = cyc;
      obs_t.addr = reg_addr;
      obs_t.data = wr_data;
      obs_q.push_back(obs_t);
      if (exp_q.size() == 0) begin
        chk("wr_valid_unexpected", 32'(wr_valid), 32'd0);
      end else begin
        chk("wr_cycle", 32'(cyc), 32'(exp_q[0].cyc));
        chk("wr_addr", 32'(reg_addr), 32'(exp_q[0].addr));
        chk("wr_data", 32'(wr_data), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      chk("wr_valid_missing", 32'(wr_valid), 32'd1);
      void'(exp_q.pop_front());
    end
    if (!busy_dc) chk("busy", 32'(busy), 32'(busy_exp));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input int c);
    wr_t e;
    if (m_in_txn) begin
      if (m_idx == 0) begin
        m_addressed = (b[7:1] == DEV) && !b[0];
        busy_exp    = m_addressed;
      end else if (m_addressed && m_idx == 1) begin
        m_ptr = b;
      end else if (m_addressed) begin
        e.cyc  = c + 2;
        e.addr = m_ptr;
        e.data = b;
        exp_q.push_back(e);
        m_ptr = m_ptr + 8'd1;
      end
      m_idx++;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_byte_en"}, 32'(byte_en), 32'd0);
    chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_reg_addr"}, 32'(reg_addr), 32'h00);
    chk({tag, "_wr_data"}, 32'(wr_data), 32'h00);
  endtask

  task automatic do_reset();
    busy_dc = 1'b1;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    m_in_txn = 1'b0;
    m_addressed = 1'b0;
    m_ptr = 8'h00;
    busy_exp = 1'b0;
    tick(1);
    chk_reset_outputs("midrst");
    busy_dc = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(4);
    scl_i = 1'b1; tick(4);
    sda_m = 1'b0; m_in_txn = 1'b1; m_idx = 0; tick(4);
    scl_i = 1'b0; tick(4);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(4);
    scl_i = 1'b1; tick(4);
    busy_dc = 1'b1;
    sda_m = 1'b1; tick(4);
    m_in_txn = 1'b0; m_addressed = 1'b0; busy_exp = 1'b0; busy_dc = 1'b0;
    tick(8);
  endtask

  task automatic send_byte(input logic [7:0] b, input int rst_at);
    bit ack_exp;
    bit is_addr;
    is_addr = m_in_txn && (m_idx == 0);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; tick(4);
      if (is_addr && i == 0) busy_dc = 1'b1;
      scl_i = 1'b1; tick(8);
      scl_i = 1'b0;
      if (i == rst_at) do_reset();
      tick(4);
    end
    ack_exp = m_in_txn && ((m_idx == 0) ? ((b[7:1] == DEV) && !b[0]) : m_addressed);
    sda_m = 1'b1; tick(4);
    scl_i = 1'b1; model_byte(b, cyc); tick(4);
    chk("ack_sda", 32'(sda_bus), 32'(!ack_exp));
    tick(4);
    scl_i = 1'b0; tick(4);
    busy_dc = 1'b0;
  endtask

  task automatic chk_obs(input int k, input logic [7:0] a, input logic [7:0] d);
    if (obs_q.size() > k) begin
      chk("obs_addr", 32'(obs_q[k].addr), 32'(a));
      chk("obs_data", 32'(obs_q[k].data), 32'(d));
    end
  endtask

  initial begin
    logic [7:0] ra;
    int nd;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
    chk_reset_outputs("reset");
    busy_dc = 1'b0;

    // Two writes with auto-increment
    obs_q.delete();
    i2c_start();
    en_falls = 0;
    send_byte(8'hA0, -1); send_byte(8'h10, -1); send_byte(8'h5A, -1); send_byte(8'hA5, -1);
    chk("t1_en_pulses", 32'(en_falls), 32'd4);
    chk("t1_busy", 32'(busy), 32'd1);
    i2c_stop();
    chk("t1_count", 32'(obs_q.size()), 32'd2);
    chk_obs(0, 8'h10, 8'h5A);
    chk_obs(1, 8'h11, 8'hA5);
    chk("t1_en_after_stop", 32'(byte_en), 32'd0);

    // Foreign address and read to own address are both ignored
    obs_q.delete();
    i2c_start(); send_byte(8'hA4, -1);
    chk("t2_en_ignore", 32'(byte_en), 32'd0);
    send_byte(8'h55, -1); i2c_stop();
    i2c_start(); send_byte(8'hA1, -1);
    chk("t3_en_ignore", 32'(byte_en), 32'd0);
    send_byte(8'h66, -1); i2c_stop();
    chk("t23_count", 32'(obs_q.size()), 32'd0);

    // Pointer wrap
    obs_q.delete();
    i2c_start();
    send_byte(8'hA0, -1); send_byte(8'hFF, -1); send_byte(8'h11, -1); send_byte(8'h22, -1);
    i2c_stop();
    chk("t4_count", 32'(obs_q.size()), 32'd2);
    chk_obs(0, 8'hFF, 8'h11);
    chk_obs(1, 8'h00, 8'h22);

    // Repeated START re-addresses without writing
    obs_q.delete();
    i2c_start(); send_byte(8'hA0, -1); send_byte(8'h20, -1);
    i2c_start(); send_byte(8'hA0, -1); send_byte(8'h33, -1);
    chk("t5_reg_addr", 32'(reg_addr), 32'h33);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_count", 32'(obs_q.size()), 32'd0);
    i2c_stop();

    // Reset in the middle of a data byte, then a fresh write
    obs_q.delete();
    i2c_start(); send_byte(8'hA0, -1); send_byte(8'h40, -1); send_byte(8'h77, 4);
    i2c_stop();
    chk("t6_count", 32'(obs_q.size()), 32'd0);
    chk_reset_outputs("t6_post");
    i2c_start(); send_byte(8'hA0, -1); send_byte(8'h07, -1); send_byte(8'h99, -1);
    i2c_stop();
    chk("t6_count2", 32'(obs_q.size()), 32'd1);
    chk_obs(0, 8'h07, 8'h99);

    // Randomized transactions, sometimes chained by repeated START
    for (int t = 0; t < 25; t++) begin
      ra = ($urandom_range(0, 9) < 6) ? 8'hA0 : 8'($urandom);
      i2c_start();
      send_byte(ra, -1);
      send_byte(8'($urandom), -1);
      nd = int'($urandom_range(0, 4));
      for (int k = 0; k < nd; k++) send_byte(8'($urandom), -1);
      if ($urandom_range(0, 3) != 0) i2c_stop();
    end
    i2c_stop();
    tick(4);
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
